// File: rtl/stream_io_pkg.sv
// Shared register map and status layout for the stream I/O peripherals.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package stream_io_pkg;

  // CPU register offsets (one address bit selects the register).
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // STATUS register bit positions.
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_COUNT_LSB = 8;

  // CPU access handshake states.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } cpu_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with head-of-queue read, occupancy count and full/empty flags.
// Latency: a pushed word is visible at head_o the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module stream_fifo #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 4,
  localparam int CNT_BITS   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_BITS-1:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_BITS-1:0]   count_q;
  logic [CNT_BITS-1:0]   count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Guard the operations so the count can never leave 0..DEPTH.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy only moves when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_BITS'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/producer2riscv.sv
// Stream-to-CPU bridge: buffers producer words and exposes DATA/STATUS registers.
// Latency: CPU response one cycle after acceptance; pushed words readable next cycle.
// Backpressure: ready_upward drops while the FIFO is full or in reset.
module producer2riscv
  import stream_io_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 4,
  localparam int CNT_BITS   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  val_in,
  output logic                  ready_upward,
  input  logic                  cpu_valid,
  input  logic                  cpu_addr,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata
);

  cpu_state_e            state_q;
  logic                  cpu_ready_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  underflow_q;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_BITS-1:0]   fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  rd_data;
  logic                  rd_status;
  logic [DATA_WIDTH-1:0] status_word;

  // Full blocks the producer even when a pop lands in the same cycle.
  assign ready_upward = !reset && !fifo_full;
  assign push         = val_in && ready_upward;

  assign accept    = (state_q == S_IDLE) && cpu_valid;
  assign rd_data   = accept && (cpu_wstrb == 4'b0) && (cpu_addr == ADDR_DATA);
  assign rd_status = accept && (cpu_wstrb == 4'b0) && (cpu_addr == ADDR_STATUS);
  assign pop       = rd_data && !fifo_empty;

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // STATUS fields sampled on the accept cycle; count is zero-extended.
  always_comb begin
    status_word                              = '0;
    status_word[ST_EMPTY]                    = fifo_empty;
    status_word[ST_FULL]                     = fifo_full;
    status_word[ST_UNDERFLOW]                = underflow_q;
    status_word[ST_COUNT_LSB +: CNT_BITS]    = fifo_count;
  end

  // Response data: writes and empty DATA reads return zero.
  always_comb begin
    rdata_d = '0;
    if (rd_status) begin
      rdata_d = status_word;
    end else if (rd_data && !fifo_empty) begin
      rdata_d = fifo_head;
    end
  end

  // CPU handshake FSM with registered ready/rdata and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cpu_ready_q <= 1'b0;
          cpu_rdata_q <= '0;
          if (cpu_valid) begin
            state_q     <= S_RESP;
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= rdata_d;
            if (rd_data && fifo_empty) begin
              underflow_q <= 1'b1;
            end else if (rd_status) begin
              underflow_q <= 1'b0;
            end
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          cpu_ready_q <= 1'b0;
          cpu_rdata_q <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          cpu_ready_q <= 1'b0;
          cpu_rdata_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_producer2riscv.sv
// Bench for producer2riscv: directed register scenarios plus a randomized stream.
// Latency: checks one-cycle CPU acknowledge and next-cycle word visibility.
// Backpressure: checks ready_upward against an occupancy model every cycle.
module tb_producer2riscv;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          val_in;
  logic          ready_upward;
  logic          cpu_valid;
  logic          cpu_addr;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  producer2riscv #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .val_in       (val_in),
    .ready_upward (ready_upward),
    .cpu_valid    (cpu_valid),
    .cpu_addr     (cpu_addr),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata)
  );

  // One CPU access, called and returning at a falling edge. lat = 0 means no ack.
  task automatic cpu_access(input logic addr, input logic [3:0] wstrb,
                            output logic [DW-1:0] rdata, output int lat,
                            output logic ru_at_ack);
    cpu_addr  = addr;
    cpu_wstrb = wstrb;
    cpu_valid = 1'b1;
    lat       = 0;
    rdata     = '0;
    ru_at_ack = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cpu_ready === 1'b1) begin
        lat       = i;
        rdata     = cpu_rdata;
        ru_at_ack = ready_upward;
        break;
      end
    end
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
    cpu_addr  = 1'b0;
    @(negedge clk);
  endtask

  // Push a word per cycle starting at base; called and returning at a falling edge.
  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      din    = base + DW'(i);
      val_in = 1'b1;
      @(negedge clk);
    end
    val_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    int            lat;
    logic          ru;
    reset = 1'b1; val_in = 1'b1; din = 32'hDEAD_BEEF;
    cpu_valid = 1'b0; cpu_addr = 1'b0; cpu_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready_upward !== 1'b0) begin n_fail++; $display("FAIL reset_ready_upward got=%b exp=0", ready_upward); end
    n_checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== '0) begin
      n_fail++; $display("FAIL reset_cpu_outputs ready=%b rdata=%h exp 0/0", cpu_ready, cpu_rdata);
    end
    val_in = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_upward !== 1'b1) begin n_fail++; $display("FAIL release_ready_upward got=%b exp=1", ready_upward); end
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got=%h exp=00000001", rd); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL reset_status_latency got=%0d exp=1", lat); end
    n_checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== '0) begin
      n_fail++; $display("FAIL ack_single_cycle ready=%b rdata=%h exp 0/0", cpu_ready, cpu_rdata);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] rd;
    int            lat;
    logic          ru;
    int            early_drop;
    early_drop = 0;
    for (int i = 0; i < DEPTH; i++) begin
      din = 32'hA5A5_0001 + DW'(i); val_in = 1'b1;
      if (ready_upward !== 1'b1) early_drop++;
      @(negedge clk);
    end
    n_checks++;
    if (early_drop != 0) begin n_fail++; $display("FAIL fill_ready_before_full lowcycles=%0d exp=0", early_drop); end
    n_checks++;
    if (ready_upward !== 1'b0) begin n_fail++; $display("FAIL fill_ready_when_full got=%b exp=0", ready_upward); end
    din = 32'hA5A5_0005;
    repeat (3) @(negedge clk);
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    val_in = 1'b0;
    n_checks++;
    if (rd !== 32'h0000_0402) begin n_fail++; $display("FAIL full_status got=%h exp=00000402", rd); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] rd;
    int            lat;
    logic          ru;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_access(1'b0, 4'h0, rd, lat, ru);
      n_checks++;
      if (rd !== 32'hA5A5_0001 + DW'(i) || lat != 1) begin
        n_fail++; $display("FAIL drain_word%0d got=%h lat=%0d exp=%h lat=1", i, rd, lat, 32'hA5A5_0001 + DW'(i));
      end
      if (i == 0) begin
        n_checks++;
        if (ru !== 1'b1) begin n_fail++; $display("FAIL ready_after_first_pop got=%b exp=1", ru); end
      end
    end
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL drained_status got=%h exp=00000001", rd); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] rd;
    int            lat;
    logic          ru;
    cpu_access(1'b0, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== '0 || lat != 1) begin n_fail++; $display("FAIL empty_read got=%h lat=%0d exp=0 lat=1", rd, lat); end
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h0000_0005) begin n_fail++; $display("FAIL underflow_status got=%h exp=00000005", rd); end
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL underflow_cleared got=%h exp=00000001", rd); end
  endtask

  // Random producer against paced DATA reads; the model is an ordered queue.
  task automatic test_stream();
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_word;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_st;
    logic          exp_is_word;
    logic          model_uf;
    logic          pushed;
    logic          push_now;
    logic          ru;
    int            lat;
    int            received;
    int            cyc;
    int            prod_pct;
    q = {}; received = 0; cyc = 0; model_uf = 1'b0; pushed = 1'b1;
    exp_word = '0; exp_is_word = 1'b0;
    val_in = 1'b0; cpu_valid = 1'b0; cpu_addr = 1'b0; cpu_wstrb = 4'h0;
    while (received < 200 && cyc < 5000) begin
      if (cpu_ready === 1'b1) begin
        n_checks++;
        if (cpu_rdata !== exp_word) begin
          n_fail++; $display("FAIL stream_word idx=%0d got=%h exp=%h", received, cpu_rdata, exp_word);
        end
        if (exp_is_word) received++;
      end else begin
        n_checks++;
        if (cpu_rdata !== '0) begin n_fail++; $display("FAIL stream_idle_rdata got=%h exp=0", cpu_rdata); end
      end
      n_checks++;
      if (ready_upward !== (q.size() != DEPTH)) begin
        n_fail++; $display("FAIL stream_ready cyc=%0d got=%b model_count=%0d", cyc, ready_upward, q.size());
      end
      if (received >= 200) break;
      prod_pct = ((cyc / 64) % 2 == 1) ? 20 : 90;
      if (!val_in || pushed) begin
        val_in = ($urandom_range(0, 99) < prod_pct);
        din    = $urandom;
      end
      if (cpu_valid) cpu_valid = 1'b0;
      else if ($urandom_range(0, 9) < 7) cpu_valid = 1'b1;
      push_now = val_in && (q.size() != DEPTH);
      if (cpu_valid) begin
        if (q.size() > 0) begin exp_word = q.pop_front(); exp_is_word = 1'b1; end
        else begin exp_word = '0; exp_is_word = 1'b0; model_uf = 1'b1; end
      end
      if (push_now) q.push_back(din);
      pushed = push_now;
      @(negedge clk);
      cyc++;
    end
    cpu_valid = 1'b0; val_in = 1'b0;
    n_checks++;
    if (received != 200) begin n_fail++; $display("FAIL stream_timeout received=%0d exp=200", received); end
    @(negedge clk);
    exp_st = (DW'(q.size()) << 8) | (DW'(model_uf) << 2) |
             (DW'(q.size() == DEPTH) << 1) | DW'(q.size() == 0);
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== exp_st) begin n_fail++; $display("FAIL stream_end_status got=%h exp=%h", rd, exp_st); end
    while (q.size() > 0) begin
      exp_word = q.pop_front();
      cpu_access(1'b0, 4'h0, rd, lat, ru);
      n_checks++;
      if (rd !== exp_word) begin n_fail++; $display("FAIL stream_tail got=%h exp=%h", rd, exp_word); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    int            lat;
    logic          ru;
    int            stray;
    push_words(32'h3000_0000, 3);
    cpu_addr = 1'b0; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    reset = 1'b1; val_in = 1'b1; din = 32'h7777_7777;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; val_in = 1'b0;
    stray = 0;
    repeat (4) begin
      if (cpu_ready !== 1'b0) stray++;
      @(negedge clk);
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL reset_drops_resp ready_cycles=%0d exp=0", stray); end
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL post_reset_status got=%h exp=00000001", rd); end
    push_words(32'h4000_0000, 2);
    cpu_access(1'b0, 4'hF, rd, lat, ru);
    n_checks++;
    if (rd !== '0 || lat != 1) begin n_fail++; $display("FAIL write_ack got=%h lat=%0d exp=0 lat=1", rd, lat); end
    cpu_access(1'b1, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h0000_0200) begin n_fail++; $display("FAIL write_no_pop_status got=%h exp=00000200", rd); end
    cpu_access(1'b0, 4'h0, rd, lat, ru);
    n_checks++;
    if (rd !== 32'h4000_0000) begin n_fail++; $display("FAIL write_no_pop_head got=%h exp=40000000", rd); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
